median3_stream_filter: RTL and testbench

Streaming 3-tap median filter for unsigned sample streams. It accepts one sample per beat over a valid/ready interface and holds a sliding window of the previous and current samples. It emits one median output per input sample, using the same 3-comparator min/max network as the team's 3-input median sorter. It sits between a sample source and downstream consumers as the frame-aware front end that serialises and windows the data the parallel sorter needs, for impulse-noise removal. Frame boundaries are marked with `last`, and edge samples are replicated at each frame end.

---
 rtl/median3_stream_filter.sv | 131 +++++++++++++
 tb/tb_median3_stream_filter.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/median3_stream_filter.sv
// Streaming 3-tap median filter with frame-aware edge replication.
// One median out per sample in; the window reseeds at every frame start and
// a FLUSH cycle emits the replicated final sample after each multi-sample frame.
module median3_stream_filter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StFlush
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] cur_q, cur_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_last_q, out_last_d;

    logic             out_free;
    logic             in_acc;
    logic [WIDTH-1:0] lo, hi, hi_c, med;

    // Handshake: the output register is free when empty or being drained this cycle
    always_comb begin
        out_free = !out_valid_q || out_ready;
        in_ready = (state_q != StFlush) && out_free;
        in_acc   = in_valid && in_ready;
    end

    // Three-comparator network: med(a,b,c) = max(min(a,b), min(max(a,b), c))
    always_comb begin
        lo   = (prev_q < cur_q) ? prev_q : cur_q;
        hi   = (prev_q < cur_q) ? cur_q : prev_q;
        hi_c = (hi < in_data) ? hi : in_data;
        med  = (lo > hi_c) ? lo : hi_c;
    end

    // Next-state: window shift, output register load/drain and frame sequencing
    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        cur_d       = cur_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        // Drain first; a reload below overrides this in the same cycle
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (in_acc) begin
                    if (in_last) begin
                        // Single-sample frame: the sample is its own median
                        out_valid_d = 1'b1;
                        out_data_d  = in_data;
                        out_last_d  = 1'b1;
                    end else begin
                        // Seed both taps so the first median replicates sample 0
                        prev_d  = in_data;
                        cur_d   = in_data;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (in_acc) begin
                    out_valid_d = 1'b1;
                    out_data_d  = med;
                    out_last_d  = 1'b0;
                    prev_d      = cur_q;
                    cur_d       = in_data;
                    if (in_last) begin
                        state_d = StFlush;
                    end
                end
            end
            StFlush: begin
                // med(prev,cur,cur) is always cur, so emit it directly
                if (out_free) begin
                    out_valid_d = 1'b1;
                    out_data_d  = cur_q;
                    out_last_d  = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            prev_q      <= '0;
            cur_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            cur_q       <= cur_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_median3_stream_filter.sv
// Self-checking bench for median3_stream_filter: directed frames, back-pressure,
// mid-frame reset and a long randomized run against a per-frame median model.
module tb_median3_stream_filter;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    int tests_run;
    int tests_failed;

    logic [7:0] stim_data[$];
    bit         stim_last[$];
    logic [7:0] exp_data[$];
    bit         exp_last[$];
    logic [7:0] got_data[$];
    bit         got_last[$];

    int         stall_viol;
    int         ready_viol;
    int         ready_low_cnt;
    bit         timed_out;
    bit         prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;

    median3_stream_filter #(
        .WIDTH(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe handshakes mid-cycle: record accepted outputs and protocol breaches
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && !(out_valid && out_data == prev_data && out_last == prev_last))
                stall_viol++;
            if (out_valid && !out_ready && in_ready) ready_viol++;
            if (!in_ready) ready_low_cnt++;
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    // Middle of three by arithmetic: sum minus largest minus smallest
    function automatic logic [7:0] median_ref(input int a, input int b, input int c);
        int mx, mn;
        mx = (a > b) ? a : b;
        mx = (mx > c) ? mx : c;
        mn = (a < b) ? a : b;
        mn = (mn < c) ? mn : c;
        return 8'(a + b + c - mx - mn);
    endfunction

    // Reference: per-frame 3-tap median with the frame's edge samples replicated
    task automatic build_expected();
        int start;
        int a, b, c;
        exp_data.delete();
        exp_last.delete();
        start = 0;
        for (int i = 0; i < stim_data.size(); i++) begin
            if (stim_last[i]) begin
                for (int k = start; k <= i; k++) begin
                    a = int'(stim_data[(k == start) ? k : k - 1]);
                    b = int'(stim_data[k]);
                    c = int'(stim_data[(k == i) ? k : k + 1]);
                    exp_data.push_back(median_ref(a, b, c));
                    exp_last.push_back(k == i);
                end
                start = i + 1;
            end
        end
    endtask

    // Stream stim_* through the DUT; inputs hold until accepted
    task automatic run_stream(input int vpct, input int rpct, input bit toggle_ready,
                              input int budget);
        int idx;
        int n;
        int cyc;
        bit accepted;
        n         = stim_data.size();
        idx       = 0;
        cyc       = 0;
        accepted  = 1'b0;
        timed_out = 1'b0;
        build_expected();
        got_data.delete();
        got_last.delete();
        stall_viol    = 0;
        ready_viol    = 0;
        ready_low_cnt = 0;
        while (idx < n || got_data.size() < exp_data.size()) begin
            if (cyc >= budget) begin
                timed_out = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            if (accepted || !in_valid) begin
                in_valid = 1'b0;
                if (idx < n && int'($urandom_range(0, 99)) < vpct) begin
                    in_valid = 1'b1;
                    in_data  = stim_data[idx];
                    in_last  = stim_last[idx];
                end
            end
            accepted = 1'b0;
            if (toggle_ready) out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            else out_ready = int'($urandom_range(0, 99)) < rpct;
            @(negedge clk);
            if (in_valid && in_ready) begin
                accepted = 1'b1;
                idx++;
            end
            cyc++;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'd99;
        in_last   = 1'b1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        tests_run++;
        if (out_data !== 8'd0 || out_last !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_out_fields: got data %0d last %b want 0 0", out_data, out_last);
        end
    endtask

    task automatic test_basic_frame();
        logic [7:0] want[5];
        want = '{8'd10, 8'd20, 8'd50, 8'd30, 8'd30};
        stim_data = '{8'd10, 8'd50, 8'd20, 8'd80, 8'd30};
        stim_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        run_stream(100, 100, 1'b0, 200);
        tests_run++;
        if (timed_out || got_data.size() != 5) begin
            tests_failed++;
            $display("FAIL basic_count: got %0d outputs want 5 (timeout %b)", got_data.size(),
                     timed_out);
        end
        for (int i = 0; i < 5 && i < got_data.size(); i++) begin
            tests_run++;
            if (got_data[i] !== want[i] || got_last[i] !== (i == 4)) begin
                tests_failed++;
                $display("FAIL basic_out[%0d]: got %0d last %b want %0d last %b", i,
                         got_data[i], got_last[i], want[i], (i == 4));
            end
        end
        tests_run++;
        if (ready_low_cnt != 1) begin
            tests_failed++;
            $display("FAIL basic_bubble: got %0d in_ready-low cycles want 1", ready_low_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] want[3];
        want = '{8'd7, 8'd3, 8'd9};
        stim_data = '{8'd7, 8'd3, 8'd9};
        stim_last = '{1'b1, 1'b0, 1'b1};
        run_stream(100, 100, 1'b0, 200);
        tests_run++;
        if (timed_out || got_data.size() != 3) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d outputs want 3 (timeout %b)", got_data.size(),
                     timed_out);
        end
        for (int i = 0; i < 3 && i < got_data.size(); i++) begin
            tests_run++;
            if (got_data[i] !== want[i] || got_last[i] !== (i != 1)) begin
                tests_failed++;
                $display("FAIL b2b_out[%0d]: got %0d last %b want %0d last %b", i, got_data[i],
                         got_last[i], want[i], (i != 1));
            end
        end
        tests_run++;
        if (ready_low_cnt != 1) begin
            tests_failed++;
            $display("FAIL b2b_bubble: got %0d in_ready-low cycles want 1", ready_low_cnt);
        end
    endtask

    task automatic test_extremes();
        stim_data = '{8'd255, 8'd0, 8'd255, 8'd4, 8'd4, 8'd4, 8'd4, 8'd0, 8'd255};
        stim_last = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        run_stream(100, 100, 1'b0, 300);
        tests_run++;
        if (timed_out || got_data.size() != exp_data.size()) begin
            tests_failed++;
            $display("FAIL extremes_count: got %0d outputs want %0d", got_data.size(),
                     exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            tests_run++;
            if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                tests_failed++;
                $display("FAIL extremes_out[%0d]: got %0d last %b want %0d last %b", i,
                         got_data[i], got_last[i], exp_data[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] want[5];
        want = '{8'd10, 8'd20, 8'd50, 8'd30, 8'd30};
        stim_data = '{8'd10, 8'd50, 8'd20, 8'd80, 8'd30};
        stim_last = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        run_stream(100, 0, 1'b1, 300);
        tests_run++;
        if (timed_out || got_data.size() != 5) begin
            tests_failed++;
            $display("FAIL bp_count: got %0d outputs want 5 (timeout %b)", got_data.size(),
                     timed_out);
        end
        for (int i = 0; i < 5 && i < got_data.size(); i++) begin
            tests_run++;
            if (got_data[i] !== want[i] || got_last[i] !== (i == 4)) begin
                tests_failed++;
                $display("FAIL bp_out[%0d]: got %0d last %b want %0d last %b", i, got_data[i],
                         got_last[i], want[i], (i == 4));
            end
        end
        tests_run++;
        if (stall_viol != 0) begin
            tests_failed++;
            $display("FAIL bp_stable: got %0d unstable stalled cycles want 0", stall_viol);
        end
        tests_run++;
        if (ready_viol != 0) begin
            tests_failed++;
            $display("FAIL bp_in_ready: got %0d stalled cycles with in_ready=1 want 0",
                     ready_viol);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] seq[3];
        int         waited;
        seq = '{8'd10, 8'd50, 8'd20};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            out_ready = 1'b1;
            in_valid  = 1'b1;
            in_data   = seq[i];
            in_last   = 1'b0;
            @(negedge clk);
            waited = 0;
            while (!in_ready && waited < 10) begin
                @(negedge clk);
                waited++;
            end
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 8'd20) begin
            tests_failed++;
            $display("FAIL midrst_pre: got valid %b data %0d want valid 1 data 20", out_valid,
                     out_data);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_post: got valid %b ready %b want valid 0 ready 1", out_valid,
                     in_ready);
        end
        stim_data = '{8'd5, 8'd6};
        stim_last = '{1'b0, 1'b1};
        run_stream(100, 100, 1'b0, 200);
        tests_run++;
        if (timed_out || got_data.size() != 2) begin
            tests_failed++;
            $display("FAIL midrst_count: got %0d outputs want 2", got_data.size());
        end
        for (int i = 0; i < 2 && i < got_data.size(); i++) begin
            tests_run++;
            if (got_data[i] !== 8'(5 + i) || got_last[i] !== (i == 1)) begin
                tests_failed++;
                $display("FAIL midrst_out[%0d]: got %0d last %b want %0d last %b", i,
                         got_data[i], got_last[i], 5 + i, (i == 1));
            end
        end
    endtask

    task automatic test_random();
        int total;
        int len;
        int sel;
        logic [7:0] v;
        stim_data.delete();
        stim_last.delete();
        total = 0;
        while (total < 10000) begin
            len = int'($urandom_range(1, 16));
            if (total + len > 10000) len = 10000 - total;
            for (int k = 0; k < len; k++) begin
                sel = int'($urandom_range(0, 7));
                if (sel == 0) v = 8'd0;
                else if (sel == 1) v = 8'd255;
                else v = 8'($urandom_range(0, 255));
                stim_data.push_back(v);
                stim_last.push_back(k == len - 1);
            end
            total += len;
        end
        run_stream(75, 65, 1'b0, 60000);
        tests_run++;
        if (timed_out || got_data.size() != exp_data.size()) begin
            tests_failed++;
            $display("FAIL random_count: got %0d outputs want %0d (timeout %b)",
                     got_data.size(), exp_data.size(), timed_out);
        end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            tests_run++;
            if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) begin
                tests_failed++;
                $display("FAIL random_out[%0d]: got %0d last %b want %0d last %b", i,
                         got_data[i], got_last[i], exp_data[i], exp_last[i]);
            end
        end
        tests_run++;
        if (stall_viol != 0 || ready_viol != 0) begin
            tests_failed++;
            $display("FAIL random_protocol: got %0d unstable, %0d ready-while-stalled want 0 0",
                     stall_viol, ready_viol);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        prev_stall   = 1'b0;
        prev_data    = 8'd0;
        prev_last    = 1'b0;
        in_valid     = 1'b0;
        in_data      = 8'd0;
        in_last      = 1'b0;
        out_ready    = 1'b0;
        rst          = 1'b1;
        test_reset();
        test_basic_frame();
        test_back_to_back();
        test_extremes();
        test_backpressure();
        test_reset_midframe();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
